// File: rtl/counter_burst_arbiter.sv
// Two-requester round-robin sequencer around a shared counter.
// A granted requester gets one counter clear, exactly len enable cycles,
// a check of the final count against len, and a one-cycle done pulse.
module counter_burst_arbiter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [CW-1:0] len0,
  input  logic [CW-1:0] len1,
  input  logic [CW-1:0] counter_out,
  output logic          cnt_reset,
  output logic          cnt_enable,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [CW-1:0] result,
  output logic          busy,
  output logic          error
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StCheck,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;       // index of the last winner
  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] result_q, result_d;
  logic          error_q, error_d;
  logic          win;

  // Round-robin pick: a lone request wins; on a tie the previous loser wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    error_d     = error_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d       = win ? 2'b10 : 2'b01;
          last_d      = win;
          target_d    = win ? len1 : len0;
          remaining_d = win ? len1 : len0;
          state_d     = StClear;
        end
      end
      StClear: begin
        state_d = (target_q != '0) ? StRun : StCheck;
      end
      StRun: begin
        remaining_d = remaining_q - CW'(1);
        if (remaining_q == CW'(1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        result_d = counter_out;
        if (counter_out != target_q) begin
          error_d = 1'b1;
        end
        state_d = StDone;
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State register; async reset abandons any burst without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      target_q    <= '0;
      remaining_q <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
      error_q     <= error_d;
    end
  end

  // Outputs decoded purely from registered state, so reset/enable never overlap.
  always_comb begin
    cnt_reset  = (state_q == StClear);
    cnt_enable = (state_q == StRun);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone) ? gnt_q : 2'b00;
    gnt        = gnt_q;
    result     = result_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_counter_burst_arbiter.sv
// Scoreboard bench for counter_burst_arbiter with a behavioural shared counter.
module tb_counter_burst_arbiter;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [CW-1:0] len0, len1;
  logic [CW-1:0] counter_out;
  logic          cnt_reset, cnt_enable, busy, error;
  logic [1:0]    gnt, done;
  logic [CW-1:0] result;

  logic [CW-1:0] cnt_q = '0;
  logic          stuck = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]    done_exp;
    logic [CW-1:0] res;
    logic          err;
    int            enables;
    int            latency;
  } exp_t;

  exp_t sb[$];

  counter_burst_arbiter #(.CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .counter_out(counter_out),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Shared counter: sync active-high clear, enable; optionally stuck at zero.
  always @(posedge clk) begin
    if (cnt_reset) cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end
  assign counter_out = stuck ? '0 : cnt_q;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push(input logic [1:0] d, input int res, input logic err, input int len);
    exp_t e;
    e.done_exp = d;
    e.res      = CW'(res);
    e.err      = err;
    e.enables  = len;
    e.latency  = len + 2;
    sb.push_back(e);
  endtask

  // Monitor: tracks enable count and grant-to-done latency, checks at each done.
  int   lat = 0;
  int   en_cnt = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] prev_done = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      lat = 0; en_cnt = 0; prev_gnt = 2'b00; prev_done = 2'b00;
    end else begin
      if (cnt_reset && cnt_enable) check("cnt_exclusive", 1, 0);
      if (gnt != 2'b00 && prev_gnt == 2'b00) lat = 0;
      else if (gnt != 2'b00) lat++;
      if (cnt_reset) en_cnt = 0;
      else if (cnt_enable) en_cnt++;
      if (done != 2'b00) begin
        if (prev_done != 2'b00) check("done_one_cycle", int'(prev_done), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done_owner", int'(done), int'(e.done_exp));
          check("gnt_at_done", int'(gnt), int'(e.done_exp));
          check("result", int'(result), int'(e.res));
          check("error", int'(error), int'(e.err));
          check("enable_cycles", en_cnt, e.enables);
          check("gnt_to_done", lat, e.latency);
        end
      end
      prev_gnt  = gnt;
      prev_done = done;
    end
  end

  task automatic wait_done(input int idx);
    int n = 0;
    while (!done[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", 0, 1);
  endtask

  task automatic run_burst(input int idx, input int len, input int res, input logic err);
    if (idx == 0) len0 = CW'(len);
    else len1 = CW'(len);
    push((idx == 0) ? 2'b01 : 2'b10, res, err, len);
    req[idx] = 1'b1;
    wait_done(idx);
    req[idx] = 1'b0;
    @(negedge clk);
    check("idle_after_done", int'({busy, gnt}), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int guard;
    reset = 1'b0;
    req   = 2'b11;
    len0  = 4'd3;
    len1  = 4'd5;

    // Held in reset with both requests pending.
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_ctl", int'({cnt_reset, cnt_enable, busy}), 0);
    check("rst_result", int'(result), 0);
    check("rst_error", int'(error), 0);

    // Contention right after reset: order 0,1,0,1 with one idle cycle between.
    push(2'b01, 3, 1'b0, 3);
    push(2'b10, 5, 1'b0, 5);
    push(2'b01, 3, 1'b0, 3);
    push(2'b10, 5, 1'b0, 5);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(k % 2);
      if (k == 3) req = 2'b00;
      @(negedge clk);
      check("rr_idle_gap", int'({busy, gnt}), 0);
      if (k < 3) begin
        @(negedge clk);
        check("rr_next_gnt", int'(gnt), (k % 2 == 0) ? 2 : 1);
        check("rr_next_busy", int'(busy), 1);
      end
    end
    @(negedge clk);

    // Single bursts and boundary lengths.
    run_burst(0, 10, 10, 1'b0);
    run_burst(0, 0, 0, 1'b0);
    run_burst(1, 15, 15, 1'b0);

    // Faulty counter sets sticky error; a good burst afterwards keeps it.
    stuck = 1'b1;
    run_burst(0, 4, 0, 1'b1);
    stuck = 1'b0;
    run_burst(1, 6, 6, 1'b1);

    // Reset mid-RUN after five enable cycles: everything drops, no done.
    len0 = 4'd12;
    req  = 2'b01;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (cnt_enable) n++;
    end
    check("midrun_reached", n, 5);
    reset = 1'b0;
    #1;
    check("midrun_enable", int'(cnt_enable), 0);
    check("midrun_gnt", int'(gnt), 0);
    check("midrun_busy", int'(busy), 0);
    check("midrun_error", int'(error), 0);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_burst(0, 12, 12, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_burst_arbiter.md
# counter_burst_arbiter

Sequencer and round-robin arbiter that shares one `first_counter` (CW-bit, synchronous active-high `reset`, `enable`) between two requesters. A requester asks for a burst of `len` counts. The block grants one requester, clears the counter, enables it for exactly `len` cycles, checks the final `counter_out` against `len`, then returns the result with a one-cycle `done` pulse. It sits between the requesting logic and the counter instance and is the only driver of the counter's `reset` and `enable`.

## Interface
- `CW`, default 4: counter width; must match the counter instance.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low block reset (0 = reset asserted).
- `req`  in  2  per-requester request; held high until that requester's `done` is seen.
- `len0`  in  CW  burst length for requester 0; sampled at grant.
- `len1`  in  CW  burst length for requester 1; sampled at grant.
- `counter_out`  in  CW  count value from the shared counter.
- `cnt_reset`  out  1  drives the counter's synchronous active-high reset.
- `cnt_enable`  out  1  drives the counter's enable.
- `gnt`  out  2  one-hot current owner; 00 when idle.
- `done`  out  2  one-cycle completion pulse to the owner.
- `result`  out  CW  `counter_out` captured in CHECK; held until the next CHECK.
- `busy`  out  1  high in every state except IDLE.
- `error`  out  1  sticky: set when the captured count differs from the latched length.

## Operation
- States: IDLE, CLEAR, RUN, CHECK, DONE. The state register is asynchronously reset to IDLE.
- IDLE:
  - If any `req` bit is high, pick a winner, set `gnt`, latch `lenX` into `target` and `remaining`, and go to CLEAR.
  - If neither bit is high, stay in IDLE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requests, the requester not granted last time wins.
  - The last-winner pointer resets to 1, so requester 0 wins the first tie.
- CLEAR: `cnt_reset`=1 for exactly one cycle. Go to RUN if `target`≠0, otherwise go to CHECK.
- RUN: `cnt_enable`=1. Each cycle `remaining` decrements. When `remaining`==1, go to CHECK; this yields exactly `target` enable cycles.
- CHECK:
  - `result` ← `counter_out`.
  - If `counter_out`≠`target`, set `error`.
  - Go to DONE.
- DONE: `done[owner]`=1 for one cycle, `gnt` stays asserted, then go to IDLE. There is always at least one IDLE cycle between bursts.
- `cnt_reset` and `cnt_enable` are decoded only from the state register and are never both high.
- `req` changes while granted are ignored. The burst always completes and `done` always pulses.
- A new `req` arriving from the other requester during a burst waits. It is arbitrated in the next IDLE.
- Width rule: `len` ≤ 2^CW−1, so a correct counter never wraps inside a burst. `target`=15 with CW=4 yields `result`=15.
- `error` clears only on `reset`.

## Timing
- Reset values (async, while `reset`=0):
  - `state`=IDLE.
  - `gnt`=00, `done`=00, `cnt_reset`=0, `cnt_enable`=0, `busy`=0.
  - `result`=0, `error`=0, `remaining`=0, `target`=0, last-winner=1.
- Reset mid-burst: all outputs drop to their reset values immediately (asynchronous). No `done` is issued, and the counter contents are left stale. The next burst's CLEAR makes them irrelevant.
- Let E0 be the posedge that samples `req` in IDLE. Cycle-by-cycle from there:
  - After E0: `gnt`, `busy`, and `cnt_reset` are high.
  - After E1 … E(len): `cnt_enable` is high (len cycles).
  - After E(len+1): CHECK.
  - After E(len+2): `done` is high.
  - After E(len+3): IDLE with `gnt`=00.
- Grant-to-done latency is len+2 cycles. Total occupancy is len+3 cycles, and len=0 occupies 3 cycles.
- The counter clears at E1 and increments at E2 … E(len+1), so `counter_out`==len during CHECK.
- Requester protocol: drop `req` on the edge where `done` is seen. Keeping `req` high into IDLE is treated as a new request.

## Test plan
- Reset: hold `reset`=0 with `req`=11 → all outputs 0 and `gnt`=00. After release, the first grant goes to requester 0.
- Single burst with a real `first_counter` instance, `req`=01, `len0`=10 → `gnt`=01, one `cnt_reset` cycle, exactly 10 `cnt_enable` cycles, `result`=10, a single `done`=01 pulse, `error`=0.
- Contention: `req`=11 held through repeated bursts, `len0`=3, `len1`=5 → grant order 0,1,0,1. Results are 3/5, each burst lasts len+3 cycles, and there is one IDLE cycle between bursts.
- Boundary lengths:
  - `len0`=0 → no `cnt_enable`, `result`=0, `done` two cycles after `gnt`.
  - `len1`=15 → `result`=15, `error`=0.
- Faulty counter: `counter_out` stuck at 0, `len0`=4 → `result`=0, `error`=1. `error` remains 1 through a subsequent good burst until `reset`.
- Reset mid-RUN: `len0`=12, assert `reset`=0 after 5 enable cycles → `cnt_enable`, `gnt`, and `busy` drop immediately, with no `done`. After release, a new request gets a full 12-cycle burst and `result`=12.
